// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state type and address-field widths for icache_dm
package icache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;

  localparam int DEF_SETS       = 16;
  localparam int DEF_LINE_WORDS = 4;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int line_words);
    return 30 - idx_w(sets) - off_w(line_words);
  endfunction

  // Counters must be able to hold LINE_WORDS itself, not just LINE_WORDS-1.
  function automatic int cnt_w(input int line_words);
    return $clog2(line_words + 1);
  endfunction

  function automatic int max1(input int w);
    return (w > 0) ? w : 1;
  endfunction

  localparam int OFF_W = off_w(DEF_LINE_WORDS);
  localparam int IDX_W = idx_w(DEF_SETS);
  localparam int TAG_W = tag_w(DEF_SETS, DEF_LINE_WORDS);

endpackage

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - line refill sequencer: request issue, response slotting, done pulse
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int SLOT_W    = max1(off_w(LINE_WORDS)),
  localparam int CNT_W     = cnt_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active_i,
  input  logic [31:0]       line_base_i,
  input  logic              mem_ready_i,
  input  logic              mem_valid_i,
  output logic [31:0]       mem_addr_o,
  output logic              mem_ren_o,
  output logic              wr_en_o,
  output logic [SLOT_W-1:0] wr_slot_o,
  output logic              done_o
);

  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] rcvd_q, rcvd_d;

  assign mem_ren_o  = active_i && (issued_q < CNT_W'(LINE_WORDS));
  assign mem_addr_o = line_base_i | (32'(issued_q) << 2);
  assign wr_en_o    = active_i && mem_valid_i;
  assign wr_slot_o  = rcvd_q[SLOT_W-1:0];
  assign done_o     = wr_en_o && (rcvd_q == CNT_W'(LINE_WORDS - 1));

  // Counters sit at zero whenever no fill is in progress, so every fill starts clean.
  always_comb begin
    issued_d = issued_q + CNT_W'(mem_ren_o && mem_ready_i);
    rcvd_d   = rcvd_q + CNT_W'(wr_en_o);
    if (!active_i) begin
      issued_d = '0;
      rcvd_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      rcvd_q   <= '0;
    end else begin
      issued_q <= issued_d;
      rcvd_q   <= rcvd_d;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with flush and hit/miss counters
module icache_dm
  import icache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic        i_ren,
  output logic        o_valid,
  output logic [31:0] o_rdata,
  input  logic        i_flush,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);

  localparam int OFF_BITS = off_w(LINE_WORDS);
  localparam int IDX_BITS = idx_w(SETS);
  localparam int TAG_BITS = tag_w(SETS, LINE_WORDS);
  localparam int SLOT_W   = max1(OFF_BITS);

  state_e state_q, state_d;

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [31:0]         data_q [SETS][LINE_WORDS];

  logic [TAG_BITS-1:0] req_tag, miss_tag_q;
  logic [IDX_BITS-1:0] req_idx, miss_idx_q;
  logic [SLOT_W-1:0]   req_off, miss_off_q, fill_slot;

  logic        hit, accept, hit_accept, miss_accept;
  logic        hit_valid_q, flush_pend_q, fill_active, resp_fill;
  logic        fill_wr, fill_done;
  logic [31:0] hit_data_q, line_base, hit_count_q, miss_count_q;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^i_addr[1:0];

  assign req_tag = i_addr[31 -: TAG_BITS];
  assign req_idx = i_addr[OFF_BITS+2 +: IDX_BITS];
  assign req_off = SLOT_W'((i_addr >> 2) & 32'(LINE_WORDS - 1));

  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept      = i_ren && o_ready;
  assign hit_accept  = accept && hit;
  assign miss_accept = accept && !hit;

  assign line_base    = {miss_tag_q, miss_idx_q, {(OFF_BITS + 2){1'b0}}};
  assign o_hit_count  = hit_count_q;
  assign o_miss_count = miss_count_q;

  icache_refill_ctrl #(.LINE_WORDS(LINE_WORDS)) u_refill (
    .clk        (clk),
    .rst        (rst),
    .active_i   (fill_active),
    .line_base_i(line_base),
    .mem_ready_i(i_mem_ready),
    .mem_valid_i(i_mem_valid),
    .mem_addr_o (o_mem_addr),
    .mem_ren_o  (o_mem_ren),
    .wr_en_o    (fill_wr),
    .wr_slot_o  (fill_slot),
    .done_o     (fill_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_accept) state_d = FILL;
      FILL:    if (fill_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready     = 1'b0;
    fill_active = 1'b0;
    resp_fill   = 1'b0;
    case (state_q)
      IDLE:    o_ready = !i_flush;
      FILL:    fill_active = 1'b1;
      RESP:    resp_fill = 1'b1;
      default: ;
    endcase
    if (rst) o_ready = 1'b0;
    o_valid = !rst && (hit_valid_q || resp_fill);
    o_rdata = resp_fill ? data_q[miss_idx_q][miss_off_q] : hit_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      hit_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_valid_q <= hit_accept;
      if (hit_accept)  hit_count_q  <= hit_count_q + 32'd1;
      if (miss_accept) miss_count_q <= miss_count_q + 32'd1;
      if (state_q == RESP)                 flush_pend_q <= 1'b0;
      else if (i_flush && state_q != IDLE) flush_pend_q <= 1'b1;
      // A flush landing on the final response cycle must also leave the line invalid.
      if (i_flush)                         valid_q <= '0;
      else if (fill_done && !flush_pend_q) valid_q[miss_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (miss_accept) begin
      miss_tag_q <= req_tag;
      miss_idx_q <= req_idx;
      miss_off_q <= req_off;
    end
    if (hit_accept) hit_data_q <= data_q[req_idx][req_off];
    if (fill_wr)    data_q[miss_idx_q][fill_slot] <= i_mem_rdata;
    if (fill_done)  tag_q[miss_idx_q] <= miss_tag_q;
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed self-checking bench for icache_dm with a LATENCY=4/INTERVAL=2 memory model
module tb_icache_dm;

  localparam int LAT      = 4;
  localparam int INTERVAL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_ready, o_valid, o_mem_ren;
  logic        i_ren = 1'b0, i_flush = 1'b0;
  logic        mem_ready = 1'b1, mem_valid = 1'b0;
  logic [31:0] i_addr = '0, o_rdata, o_mem_addr, mem_rdata = '0;
  logic [31:0] o_hit_count, o_miss_count;

  int          n_checks = 0, n_errors = 0;
  int          cyc = 0, cool = 0, valid_pulses = 0;
  logic [31:0] req_log[$];
  logic [31:0] q_addr[$];
  int          q_due[$];

  always #5 clk = ~clk;

  icache_dm dut (
    .clk         (clk),
    .rst         (rst),
    .o_ready     (o_ready),
    .i_addr      (i_addr),
    .i_ren       (i_ren),
    .o_valid     (o_valid),
    .o_rdata     (o_rdata),
    .i_flush     (i_flush),
    .o_mem_addr  (o_mem_addr),
    .o_mem_ren   (o_mem_ren),
    .i_mem_ready (mem_ready),
    .i_mem_valid (mem_valid),
    .i_mem_rdata (mem_rdata),
    .o_hit_count (o_hit_count),
    .o_miss_count(o_miss_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h44) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Backing memory: one accept every INTERVAL cycles, in-order response LAT cycles later.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      mem_valid <= 1'b0;
      mem_ready <= 1'b1;
      cool = 0;
    end else begin
      if (o_mem_ren && mem_ready) begin
        q_addr.push_back(o_mem_addr);
        q_due.push_back(cyc + LAT);
        req_log.push_back(o_mem_addr);
        mem_ready <= 1'b0;
        cool = INTERVAL - 1;
      end else if (cool > 0) begin
        cool--;
        if (cool == 0) mem_ready <= 1'b1;
      end
      mem_valid <= 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc + 1) begin
        mem_valid <= 1'b1;
        mem_rdata <= mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
    end
  end

  always @(negedge clk) if (o_valid === 1'b1) valid_pulses++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Issue one read; lat counts cycles from accept to o_valid (-1 on timeout).
  task automatic do_read(input logic [31:0] addr, output int lat, output logic [31:0] data,
                         output bit rdy_low);
    int w;
    @(negedge clk);
    i_addr = addr;
    i_ren  = 1'b1;
    w = 0;
    while (o_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    i_ren   = 1'b0;
    lat     = 1;
    rdy_low = 1'b1;
    while (o_valid !== 1'b1 && lat < 100) begin
      if (o_ready !== 1'b0) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (o_valid !== 1'b1) lat = -1;
    data = o_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (o_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++; if (o_mem_ren !== 1'b0) begin n_errors++; $display("FAIL reset_mem_ren: got %b want 0", o_mem_ren); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (o_hit_count !== 32'd0) begin n_errors++; $display("FAIL reset_hits: got %0d want 0", o_hit_count); end
    n_checks++; if (o_miss_count !== 32'd0) begin n_errors++; $display("FAIL reset_misses: got %0d want 0", o_miss_count); end
    n_checks++; if (o_ready !== 1'b1) begin n_errors++; $display("FAIL idle_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_cold_miss();
    int lat, base, p0;
    logic [31:0] data, want;
    bit rdy_low;
    base = req_log.size();
    p0   = valid_pulses;
    do_read(32'h44, lat, data, rdy_low);
    n_checks++; if (lat !== 12) begin n_errors++; $display("FAIL cold_latency: got %0d want 12", lat); end
    n_checks++; if (data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL cold_data: got %h want deadbeef", data); end
    n_checks++; if (rdy_low !== 1'b1) begin n_errors++; $display("FAIL cold_ready_low: got %b want 1", rdy_low); end
    @(negedge clk);
    #1;
    n_checks++; if (req_log.size() - base !== 4) begin n_errors++; $display("FAIL cold_req_count: got %0d want 4", req_log.size() - base); end
    for (int k = 0; k < 4; k++) begin
      want = 32'h40 + 32'(4 * k);
      n_checks++;
      if (base + k >= req_log.size() || req_log[base + k] !== want) begin
        n_errors++;
        $display("FAIL cold_req_addr%0d: got %h want %h", k, (base + k < req_log.size()) ? req_log[base + k] : 32'hx, want);
      end
    end
    n_checks++; if (valid_pulses - p0 !== 1) begin n_errors++; $display("FAIL cold_pulses: got %0d want 1", valid_pulses - p0); end
    n_checks++; if (o_miss_count !== 32'd1) begin n_errors++; $display("FAIL cold_misses: got %0d want 1", o_miss_count); end
    n_checks++; if (o_hit_count !== 32'd0) begin n_errors++; $display("FAIL cold_hits: got %0d want 0", o_hit_count); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [31:0] addrs[3];
    addrs[0] = 32'h40; addrs[1] = 32'h48; addrs[2] = 32'h4C;
    base = req_log.size();
    @(negedge clk);
    i_addr = addrs[0];
    i_ren  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid%0d: got %b want 1", k, o_valid); end
      n_checks++; if (o_rdata !== mem_word(addrs[k])) begin n_errors++; $display("FAIL b2b_data%0d: got %h want %h", k, o_rdata, mem_word(addrs[k])); end
      if (k < 2) i_addr = addrs[k + 1];
      else       i_ren = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_valid: got %b want 0", o_valid); end
    n_checks++; if (o_hit_count !== 32'd3) begin n_errors++; $display("FAIL b2b_hits: got %0d want 3", o_hit_count); end
    n_checks++; if (o_miss_count !== 32'd1) begin n_errors++; $display("FAIL b2b_misses: got %0d want 1", o_miss_count); end
    n_checks++; if (req_log.size() - base !== 0) begin n_errors++; $display("FAIL b2b_mem_reqs: got %0d want 0", req_log.size() - base); end
  endtask

  task automatic test_conflict();
    int lat, base;
    logic [31:0] data;
    logic [31:0] seq[3];
    bit rdy_low;
    seq[0] = 32'h000; seq[1] = 32'h100; seq[2] = 32'h000;
    base = req_log.size();
    for (int k = 0; k < 3; k++) begin
      do_read(seq[k], lat, data, rdy_low);
      n_checks++; if (lat !== 12) begin n_errors++; $display("FAIL conflict_latency%0d: got %0d want 12", k, lat); end
      n_checks++; if (data !== mem_word(seq[k])) begin n_errors++; $display("FAIL conflict_data%0d: got %h want %h", k, data, mem_word(seq[k])); end
    end
    @(negedge clk);
    n_checks++; if (o_miss_count !== 32'd4) begin n_errors++; $display("FAIL conflict_misses: got %0d want 4", o_miss_count); end
    n_checks++; if (req_log.size() - base !== 12) begin n_errors++; $display("FAIL conflict_reqs: got %0d want 12", req_log.size() - base); end
    n_checks++; if (req_log[req_log.size() - 4] !== 32'h0) begin n_errors++; $display("FAIL conflict_refill_addr: got %h want 00000000", req_log[req_log.size() - 4]); end
  endtask

  task automatic test_flush_idle();
    int lat, base;
    logic [31:0] data;
    bit rdy_low;
    do_read(32'h40, lat, data, rdy_low);
    n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL preflush_hit_latency: got %0d want 1", lat); end
    @(negedge clk);
    i_flush = 1'b1;
    #1;
    n_checks++; if (o_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", o_ready); end
    @(negedge clk);
    i_flush = 1'b0;
    base = req_log.size();
    do_read(32'h44, lat, data, rdy_low);
    n_checks++; if (lat !== 12) begin n_errors++; $display("FAIL flush_idle_latency: got %0d want 12", lat); end
    n_checks++; if (data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL flush_idle_data: got %h want deadbeef", data); end
    @(negedge clk);
    n_checks++; if (req_log.size() - base !== 4) begin n_errors++; $display("FAIL flush_idle_reqs: got %0d want 4", req_log.size() - base); end
    n_checks++; if (o_miss_count !== 32'd5) begin n_errors++; $display("FAIL flush_idle_misses: got %0d want 5", o_miss_count); end
    n_checks++; if (o_hit_count !== 32'd4) begin n_errors++; $display("FAIL flush_idle_hits: got %0d want 4", o_hit_count); end
  endtask

  task automatic test_flush_mid_fill();
    int lat, base;
    logic [31:0] data;
    bit flushed, rdy_low;
    base = req_log.size();
    @(negedge clk);
    i_addr = 32'h80;
    i_ren  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ren   = 1'b0;
    lat     = 1;
    flushed = 1'b0;
    while (o_valid !== 1'b1 && lat < 100) begin
      if (!flushed && req_log.size() - base >= 2) begin
        i_flush = 1'b1;
        flushed = 1'b1;
      end else begin
        i_flush = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    i_flush = 1'b0;
    if (o_valid !== 1'b1) lat = -1;
    n_checks++; if (flushed !== 1'b1) begin n_errors++; $display("FAIL midflush_issued: got %b want 1", flushed); end
    n_checks++; if (lat !== 12) begin n_errors++; $display("FAIL midflush_latency: got %0d want 12", lat); end
    n_checks++; if (o_rdata !== mem_word(32'h80)) begin n_errors++; $display("FAIL midflush_data: got %h want %h", o_rdata, mem_word(32'h80)); end
    do_read(32'h80, lat, data, rdy_low);
    n_checks++; if (lat !== 12) begin n_errors++; $display("FAIL midflush_refetch_latency: got %0d want 12", lat); end
    n_checks++; if (data !== mem_word(32'h80)) begin n_errors++; $display("FAIL midflush_refetch_data: got %h want %h", data, mem_word(32'h80)); end
    @(negedge clk);
    n_checks++; if (o_miss_count !== 32'd7) begin n_errors++; $display("FAIL midflush_misses: got %0d want 7", o_miss_count); end
  endtask

  task automatic test_reset_mid_fill();
    int lat, p0;
    logic [31:0] data;
    bit rdy_low;
    @(negedge clk);
    i_addr = 32'hC0;
    i_ren  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ren = 1'b0;
    @(negedge clk);
    p0  = valid_pulses;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    n_checks++; if (valid_pulses - p0 !== 0) begin n_errors++; $display("FAIL rstfill_pulses: got %0d want 0", valid_pulses - p0); end
    n_checks++; if (o_miss_count !== 32'd0) begin n_errors++; $display("FAIL rstfill_misses: got %0d want 0", o_miss_count); end
    n_checks++; if (o_hit_count !== 32'd0) begin n_errors++; $display("FAIL rstfill_hits: got %0d want 0", o_hit_count); end
    do_read(32'hC0, lat, data, rdy_low);
    n_checks++; if (lat !== 12) begin n_errors++; $display("FAIL rstfill_refetch_latency: got %0d want 12", lat); end
    n_checks++; if (data !== mem_word(32'hC0)) begin n_errors++; $display("FAIL rstfill_refetch_data: got %h want %h", data, mem_word(32'hC0)); end
    @(negedge clk);
    n_checks++; if (o_miss_count !== 32'd1) begin n_errors++; $display("FAIL rstfill_refetch_misses: got %0d want 1", o_miss_count); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_flush_idle();
    test_flush_mid_fill();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
